// File: rtl/vend_pkg.sv
// ----------------------------------------------------------------------------
// vend_pkg
// Shared types and constants for the vending coin-acceptor path.
//   coin_state_t            : pulse-train decoder FSM states
//   CREDIT_W                : width of the credit value bus (16)
//   CNT_W                   : width of the internal timing/pulse counters (32)
//   DEFAULT_CENTS_PER_PULSE : default credit value of one acceptor pulse
//   credit_of()             : pulses * cents, truncated to CREDIT_W
// ----------------------------------------------------------------------------
package vend_pkg;

    localparam int unsigned CREDIT_W                = 16;
    localparam int unsigned CNT_W                   = 32;
    localparam int unsigned DEFAULT_CENTS_PER_PULSE = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIGH = 3'd1,
        ST_GAP  = 3'd2,
        ST_EMIT = 3'd3,
        ST_JAM  = 3'd4
    } coin_state_t;

    // Credit for a finished train; upper product bits are deliberately dropped.
    function automatic logic [CREDIT_W-1:0] credit_of(
        input logic [CNT_W-1:0] pulses,
        input int unsigned      cents
    );
        logic [CNT_W-1:0] prod;
        prod = pulses * CNT_W'(cents);
        return CREDIT_W'(prod);
    endfunction

endpackage : vend_pkg

// File: rtl/coin_sync.sv
// ----------------------------------------------------------------------------
// coin_sync
// Two-flop synchroniser plus edge detect for the raw coin-acceptor pulse.
// Ports:
//   Clk, nRst   : clock, asynchronous active-low reset
//   i_async     : raw pulse, asynchronous to Clk
//   o_level     : synchronised level (registered)
//   o_rise_c    : one-cycle strobe on a synchronised rising edge
//   o_fall_c    : one-cycle strobe on a synchronised falling edge
// A level already high when reset releases never produces a rise strobe:
// rises are only reported once the input has been seen low after the
// synchroniser pipeline has filled with real samples.
// ----------------------------------------------------------------------------
module coin_sync (
    input  logic Clk,
    input  logic nRst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [1:0] r_fill;
    logic       r_armed;

    // Synchroniser, previous-level history and post-reset arming.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_fill  <= {r_fill[0], 1'b1};
            // r_fill[1] marks that r_sync now holds a genuine post-reset sample
            r_armed <= r_armed | (r_fill[1] & ~r_sync);
        end
    end

    assign o_level  = r_sync;
    assign o_rise_c = r_sync & ~r_prev & r_armed;
    assign o_fall_c = ~r_sync & r_prev;

endmodule : coin_sync

// File: rtl/coin_pulse_decoder.sv
// ----------------------------------------------------------------------------
// coin_pulse_decoder
// Decodes the pulse train of a coin acceptor into a credit value.  Pulses
// shorter than MinPulseCycles are glitches, a low gap of GapCycles ends a
// train, a train longer than MaxPulses or a stuck-high input is discarded
// with an error strobe.
// Ports:
//   Clk, nRst    : clock, asynchronous active-low reset
//   CoinPulse    : raw active-high acceptor pulse (asynchronous)
//   Enable       : coin acceptance permitted when high
//   Inhibit      : registered ~Enable, drives the acceptor reject line
//   CreditValid  : one-cycle strobe, a coin was decoded
//   CreditValue  : decoded value, held until the next CreditValid
//   ErrorPulse   : one-cycle strobe, a train was discarded
//   CoinCount    : accepted-coin counter
// Build option: define COIN_PULSE_STATS_EN to implement CoinCount (wraps at
// 65535); otherwise the counter is absent and CoinCount reads 0.
// ----------------------------------------------------------------------------
module coin_pulse_decoder
    import vend_pkg::*;
#(
    parameter int unsigned ClockFrequency = 50000000,
    parameter int unsigned GapTimeMs      = 150,
    parameter int unsigned MinPulseCycles = 50000,
    parameter int unsigned CentsPerPulse  = DEFAULT_CENTS_PER_PULSE,
    parameter int unsigned MaxPulses      = 20
) (
    input  logic                Clk,
    input  logic                nRst,
    input  logic                CoinPulse,
    input  logic                Enable,
    output logic                Inhibit,
    output logic                CreditValid,
    output logic [CREDIT_W-1:0] CreditValue,
    output logic                ErrorPulse,
    output logic [15:0]         CoinCount
);

    localparam int unsigned GapCycles = ClockFrequency / 1000 * GapTimeMs;

    logic              w_level;
    logic              w_rise;
    logic              w_fall;

    coin_state_t       r_state;
    coin_state_t       w_next_state;

    logic [CNT_W-1:0]  r_width;
    logic [CNT_W-1:0]  r_gap;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_width_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_long_enough;
    logic              w_over_max;
    logic              w_jam;
    logic              w_gap_done;

    logic              w_credit_valid_d;
    logic              w_error_d;
    logic [CREDIT_W-1:0] w_credit_value_d;
    logic              w_count_inc;

    logic              r_inhibit;
    logic              r_credit_valid;
    logic              r_error;
    logic [CREDIT_W-1:0] r_credit_value;

    // Synchroniser and edge detect.
    coin_sync u_sync (
        .Clk      (Clk),
        .nRst     (nRst),
        .i_async  (CoinPulse),
        .o_level  (w_level),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    // w_width_nxt is the pulse width including the current HIGH cycle.
    assign w_width_nxt   = r_width + CNT_W'(1);
    assign w_long_enough = (w_width_nxt >= CNT_W'(MinPulseCycles));
    assign w_count_nxt   = r_count + CNT_W'(1);
    assign w_over_max    = (w_count_nxt > CNT_W'(MaxPulses));
    assign w_jam         = w_level && (w_width_nxt >= CNT_W'(GapCycles));
    assign w_gap_done    = (r_gap >= CNT_W'(GapCycles - 1));

    // State register.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; Enable low beats everything while a train is open,
    // and a rise beats the gap timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise && Enable) begin
                    w_next_state = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (!Enable) begin
                    w_next_state = ST_IDLE;
                end else if (w_fall) begin
                    if (w_long_enough) begin
                        w_next_state = w_over_max ? ST_JAM : ST_GAP;
                    end else begin
                        w_next_state = (r_count != '0) ? ST_GAP : ST_IDLE;
                    end
                end else if (w_jam) begin
                    w_next_state = ST_JAM;
                end
            end
            ST_GAP: begin
                if (!Enable) begin
                    w_next_state = ST_IDLE;
                end else if (w_rise) begin
                    w_next_state = ST_HIGH;
                end else if (w_gap_done) begin
                    w_next_state = ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_next_state = ST_IDLE;
            end
            ST_JAM: begin
                if (!w_level) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode from transitions, so the registered strobes line up
    // with the EMIT cycle.  HIGH->JAM is the only error path, GAP->EMIT the
    // only credit path, hence the two strobes are mutually exclusive.
    always_comb begin
        w_credit_valid_d = 1'b0;
        w_error_d        = 1'b0;
        w_credit_value_d = r_credit_value;
        w_count_inc      = 1'b0;
        if (r_state == ST_GAP && w_next_state == ST_EMIT) begin
            w_credit_valid_d = 1'b1;
            w_credit_value_d = credit_of(r_count, CentsPerPulse);
        end
        if (r_state == ST_HIGH && w_next_state == ST_JAM) begin
            w_error_d = 1'b1;
        end
        if (r_state == ST_HIGH && w_next_state == ST_GAP && w_long_enough) begin
            w_count_inc = 1'b1;
        end
    end

    // Width, gap and pulse counters; each restarts when its state is left.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            r_width <= '0;
            r_gap   <= '0;
            r_count <= '0;
        end else begin
            r_width <= (r_state == ST_HIGH && w_next_state == ST_HIGH) ? w_width_nxt : '0;
            r_gap   <= (r_state == ST_GAP && w_next_state == ST_GAP) ? r_gap + CNT_W'(1) : '0;
            if (w_next_state inside {ST_IDLE, ST_JAM}) begin
                r_count <= '0;
            end else if (w_count_inc) begin
                r_count <= w_count_nxt;
            end
        end
    end

    // Output registers.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            r_inhibit      <= 1'b1;
            r_credit_valid <= 1'b0;
            r_error        <= 1'b0;
            r_credit_value <= '0;
        end else begin
            r_inhibit      <= ~Enable;
            r_credit_valid <= w_credit_valid_d;
            r_error        <= w_error_d;
            r_credit_value <= w_credit_value_d;
        end
    end

    assign Inhibit     = r_inhibit;
    assign CreditValid = r_credit_valid;
    assign ErrorPulse  = r_error;
    assign CreditValue = r_credit_value;

`ifdef COIN_PULSE_STATS_EN
    logic [15:0] r_coin_count;

    // Accepted-coin counter, advanced together with CreditValid.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            r_coin_count <= '0;
        end else if (w_credit_valid_d) begin
            r_coin_count <= r_coin_count + 16'd1;
        end
    end

    assign CoinCount = r_coin_count;
`else
    assign CoinCount = '0;
`endif

endmodule : coin_pulse_decoder

// File: tb/tb_coin_pulse_decoder.sv
// ----------------------------------------------------------------------------
// tb_coin_pulse_decoder
// Scoreboarded bench: directed pulse trains push their expected strobe
// (kind, value, cycle) into a queue; a negedge monitor pops and compares
// every CreditValid/ErrorPulse the decoder presents.
// Timing reference: an input driven just after the edge that sets cyc=n is
// seen by the FSM in cycle n+2; a credit appears in cycle fall+2+GapCycles+1.
// ----------------------------------------------------------------------------
module tb_coin_pulse_decoder;

    localparam int unsigned CLK_FREQ = 100000;
    localparam int unsigned GAP_MS   = 2;
    localparam int unsigned MIN_PC   = 10;
    localparam int unsigned CENTS    = 5;
    localparam int unsigned MAXP     = 20;
    localparam int          CREDIT_LAT = 2 + 200 + 1;   // sync + GapCycles + 1

    logic        Clk       = 1'b0;
    logic        nRst      = 1'b0;
    logic        CoinPulse = 1'b0;
    logic        Enable    = 1'b0;
    logic        Inhibit;
    logic        CreditValid;
    logic [15:0] CreditValue;
    logic        ErrorPulse;
    logic [15:0] CoinCount;

    coin_pulse_decoder #(
        .ClockFrequency (CLK_FREQ),
        .GapTimeMs      (GAP_MS),
        .MinPulseCycles (MIN_PC),
        .CentsPerPulse  (CENTS),
        .MaxPulses      (MAXP)
    ) dut (
        .Clk         (Clk),
        .nRst        (nRst),
        .CoinPulse   (CoinPulse),
        .Enable      (Enable),
        .Inhibit     (Inhibit),
        .CreditValid (CreditValid),
        .CreditValue (CreditValue),
        .ErrorPulse  (ErrorPulse),
        .CoinCount   (CoinCount)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int val;
        int at;
    } exp_t;

    exp_t sb[$];
    int   n_chk     = 0;
    int   n_pass    = 0;
    int   exp_coins = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse(input int hi, input int lo, output int fall_cyc);
        CoinPulse = 1'b1;
        tick(hi);
        CoinPulse = 1'b0;
        fall_cyc  = cyc;
        tick(lo);
    endtask

    task automatic push_credit(input int val, input int at);
        exp_t e;
        e.is_err = 1'b0;
        e.val    = val;
        e.at     = at;
        sb.push_back(e);
        exp_coins++;
    endtask

    task automatic push_err(input int at);
        exp_t e;
        e.is_err = 1'b1;
        e.val    = 0;
        e.at     = at;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    function automatic int exp_coin_count();
`ifdef COIN_PULSE_STATS_EN
        return exp_coins;
`else
        return 0;
`endif
    endfunction

    // Monitor: every strobe must match the oldest expectation.
    always @(negedge Clk) begin : mon
        exp_t e;
        if (nRst && (CreditValid || ErrorPulse)) begin
            chk("strobe_exclusive", CreditValid & ErrorPulse, 0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {CreditValid, ErrorPulse}, 0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", ErrorPulse, e.is_err);
                if (!e.is_err) chk("credit_value", CreditValue, e.val);
                if (e.at >= 0) chk("strobe_cycle", cyc, e.at);
            end
        end
    end

    initial begin : stim
        int f;
        int s;

        // Reset state
        tick(3);
        chk("rst_credit_valid", CreditValid, 0);
        chk("rst_error", ErrorPulse, 0);
        chk("rst_credit_value", CreditValue, 0);
        chk("rst_coin_count", CoinCount, 0);
        chk("rst_inhibit", Inhibit, 1);
        nRst   = 1'b1;
        Enable = 1'b1;
        tick(5);
        chk("inhibit_enabled", Inhibit, 0);

        // Four good pulses -> 20, exact latency
        for (int i = 0; i < 4; i++) pulse(20, 50, f);
        push_credit(20, f + CREDIT_LAT);
        tick(250);
        drain("s1_drain");
        chk("s1_value_held", CreditValue, 20);

        // Glitch mid-train is ignored -> 15
        pulse(20, 50, f);
        pulse(20, 50, f);
        pulse(4, 50, f);
        pulse(20, 50, f);
        push_credit(15, f + CREDIT_LAT);
        tick(250);
        drain("s2_drain");

        // Exactly MaxPulses -> 100
        for (int i = 0; i < 20; i++) pulse(20, 30, f);
        push_credit(100, f + CREDIT_LAT);
        tick(250);
        drain("s3_drain");

        // MaxPulses+1 -> error on the 21st fall, then back to normal
        for (int i = 0; i < 20; i++) pulse(20, 30, f);
        s = cyc;
        push_err(s + 20 + 3);
        pulse(20, 30, f);
        tick(250);
        drain("s4_err_drain");
        pulse(20, 30, f);
        push_credit(5, f + CREDIT_LAT);
        tick(250);
        drain("s4_recover_drain");

        // Stuck high -> jam error at width 200, then a 2-pulse train -> 10
        s = cyc;
        push_err(s + CREDIT_LAT);
        CoinPulse = 1'b1;
        tick(250);
        CoinPulse = 1'b0;
        tick(50);
        pulse(20, 50, f);
        pulse(20, 50, f);
        push_credit(10, f + CREDIT_LAT);
        tick(250);
        drain("s5_drain");

        // Enable dropped in GAP -> silent discard; pulses while disabled ignored
        pulse(20, 50, f);
        pulse(20, 20, f);
        Enable = 1'b0;
        tick(2);
        chk("s6_inhibit_set", Inhibit, 1);
        tick(300);
        for (int i = 0; i < 3; i++) pulse(20, 50, f);
        tick(250);
        chk("s6_inhibit_held", Inhibit, 1);
        drain("s6_drain");
        Enable = 1'b1;
        tick(2);
        chk("s6_inhibit_clear", Inhibit, 0);

        // Rise lands on the gap-timeout cycle -> train continues -> 10
        pulse(20, 200, f);
        pulse(20, 50, f);
        push_credit(10, f + CREDIT_LAT);
        tick(250);
        drain("s7_drain");
        chk("coin_count", CoinCount, exp_coin_count());

        // Reset mid-train: outputs cleared, no strobe afterwards
        pulse(20, 30, f);
        CoinPulse = 1'b1;
        tick(10);
        nRst = 1'b0;
        #1;
        chk("s8_rst_credit_value", CreditValue, 0);
        chk("s8_rst_credit_valid", CreditValid, 0);
        chk("s8_rst_error", ErrorPulse, 0);
        chk("s8_rst_coin_count", CoinCount, 0);
        chk("s8_rst_inhibit", Inhibit, 1);
        exp_coins = 0;
        CoinPulse = 1'b0;
        tick(3);
        nRst = 1'b1;
        tick(300);
        drain("s8_drain");

        // Input held high across reset release must not count
        nRst      = 1'b0;
        CoinPulse = 1'b1;
        tick(3);
        nRst = 1'b1;
        tick(30);
        CoinPulse = 1'b0;
        tick(300);
        drain("s9_held_drain");
        pulse(20, 50, f);
        push_credit(5, f + CREDIT_LAT);
        tick(250);
        drain("s9_train_drain");
        chk("coin_count_final", CoinCount, exp_coin_count());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_coin_pulse_decoder

// File: doc/coin_pulse_decoder.md
COIN_PULSE_DECODER -- requirements
Module: coin_pulse_decoder

Interface
REQ-001 Parameter ClockFrequency, default 50000000, Clk frequency in Hz.
REQ-002 Parameter GapTimeMs, default 150, idle-low time that ends a pulse train.
REQ-003 Parameter MinPulseCycles, default 50000, minimum synchronised high width for a pulse to count (1 ms at default clock).
REQ-004 Parameter CentsPerPulse, default 5, credit value of one pulse.
REQ-005 Parameter MaxPulses, default 20, largest legal pulses per train.
REQ-006 Clk  in  1  system clock.
REQ-007 nRst  in  1  reset: asynchronous, active-low.
REQ-008 CoinPulse  in  1  raw active-high coin-acceptor pulse, asynchronous to Clk.
REQ-009 Enable  in  1  coin acceptance permitted when high.
REQ-010 Inhibit  out  1  registered ~Enable, drives the acceptor's reject line.
REQ-011 CreditValid  out  1  one-cycle strobe: a coin is decoded.
REQ-012 CreditValue  out  16  decoded value in credit units, valid with CreditValid and held until the next strobe.
REQ-013 ErrorPulse  out  1  one-cycle strobe: a train was discarded.
REQ-014 CoinCount  out  16  accepted-coin counter (see Configuration).

Function
REQ-015 CoinPulse shall pass through a 2-flop synchroniser; all logic shall use the synchronised level only.
REQ-016 GapCycles shall equal ClockFrequency/1000*GapTimeMs; the counters shall be 32 bits wide.
REQ-017 FSM states: IDLE, HIGH, GAP, EMIT, JAM.
REQ-018 IDLE: on a synchronised rising edge with Enable=1, go to HIGH and clear the width counter; with Enable=0, ignore the edge.
REQ-019 HIGH: count width each cycle; on a falling edge with width>=MinPulseCycles, increment the pulse count and go to GAP; on a falling edge with width<MinPulseCycles, treat it as a glitch and return to GAP if count>0, otherwise to IDLE.
REQ-020 HIGH: if width reaches GapCycles while still high, treat it as a jam: assert ErrorPulse, discard the train and go to JAM.
REQ-021 JAM: stay until the synchronised input is low, then go to IDLE.
REQ-022 GAP: on a rising edge, go to HIGH; otherwise, when the gap counter reaches GapCycles-1, go to EMIT.
REQ-023 A rising edge in the same cycle as the gap timeout shall win: the train continues.
REQ-024 EMIT: for one cycle, assert CreditValid with CreditValue=count*CentsPerPulse (truncated to 16 bits), clear the count and go to IDLE.
REQ-025 A pulse that would make count exceed MaxPulses shall trigger ErrorPulse, discard the train and go to JAM.
REQ-026 Enable falling while in HIGH or GAP shall discard the train silently (no strobe) and go to IDLE.
REQ-027 Latency from the synchronised falling edge of the last pulse to CreditValid shall be GapCycles+1 cycles.
REQ-028 CreditValid and ErrorPulse shall never assert in the same cycle.

Reset
REQ-029 On nRst low: state IDLE; all counters 0; CreditValid=0, ErrorPulse=0, CreditValue=0, CoinCount=0; Inhibit=1; synchroniser flops 0.
REQ-030 Reset mid-train shall drop the train with no strobe after release.
REQ-031 A CoinPulse held high across reset release shall not count as a pulse; only a later rising edge starts a train.

Configuration
REQ-032 Macro COIN_PULSE_STATS_EN defined: CoinCount shall increment on every CreditValid and wrap 65535->0.
REQ-033 Macro COIN_PULSE_STATS_EN undefined: the counter logic shall be absent and CoinCount shall be tied to 0.

Structure
REQ-034 Shared package vend_pkg shall hold the FSM state enum, the CREDIT_W=16 constant and the default CentsPerPulse.
REQ-035 The synchroniser and edge detect shall be a sub-module, coin_sync, outputting the level plus rise and fall strobes.

Verification
All scenarios use ClockFrequency=100000, GapTimeMs=2 (GapCycles=200), MinPulseCycles=10, CentsPerPulse=5, MaxPulses=20.
REQ-036 Enable=1, 4 pulses 20 high / 50 low -> one CreditValid, CreditValue=20, 201 cycles after the last synchronised fall.
REQ-037 3 good pulses plus a 4-cycle glitch mid-train -> CreditValue=15, no ErrorPulse.
REQ-038 21 good pulses -> ErrorPulse on the 21st, no CreditValid, returns to IDLE after the input goes low.
REQ-039 CoinPulse held high for 250 cycles -> ErrorPulse at width 200, no credit; a following 2-pulse train -> CreditValue=10.
REQ-040 Enable dropped during GAP after 2 pulses -> no strobe, Inhibit=1 two cycles later; pulses while Enable=0 -> no output.
REQ-041 Rising edge on the exact gap-timeout cycle -> train continues and the count includes the pulse; nRst asserted mid-train -> outputs 0 and no strobe.
